// File: rtl/pulse_period_meter_pkg.sv
// Shared definitions for the tick period meter: state encoding and parameter defaults.
package pulse_period_meter_pkg;

    localparam int unsigned DEFAULT_WIDTH      = 32;
    localparam logic [31:0] DEFAULT_MAX_PERIOD = 32'd1000000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ARM  = 2'b01,
        ST_MEAS = 2'b10
    } state_t;

endpackage

// File: rtl/rising_edge_detect.sv
// One-cycle rising-edge strobe on tick; the history register resets high so a
// strobe already high when reset is released is not mistaken for an edge.
module rising_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic tick_edge
);

    logic tick_q_r;

    // Previous-cycle sample of tick
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q_r <= 1'b1;
        end else begin
            tick_q_r <= tick;
        end
    end

    assign tick_edge = tick & ~tick_q_r;

endmodule

// File: rtl/pulse_period_meter.sv
// Measures clk cycles between consecutive rising edges of tick and presents each
// interval through a valid/ready result register with overrun and timeout flags.
module pulse_period_meter
    import pulse_period_meter_pkg::*;
#(
    parameter int unsigned      WIDTH      = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] MAX_PERIOD = WIDTH'(DEFAULT_MAX_PERIOD)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             tick,
    output logic [WIDTH-1:0] period,
    output logic             period_valid,
    input  logic             period_ready,
    output logic             overrun,
    output logic             timeout
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state_r;
    logic [WIDTH-1:0] cnt_r;
    logic             timeout_r;
    logic [WIDTH-1:0] period_r;
    logic             period_valid_r;
    logic             overrun_r;
    logic             edge_s;
    logic             emit_s;
    logic             accept_s;

    rising_edge_detect u_edge (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .tick_edge (edge_s)
    );

    // A result exists only for an edge seen while measuring with en high
    assign emit_s   = en & (state_r == ST_MEAS) & edge_s;
    assign accept_s = period_valid_r & period_ready;

    // Measurement FSM, interval counter and timeout pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            timeout_r <= 1'b0;
        end else if (!en) begin
            state_r   <= ST_IDLE;
            cnt_r     <= CNT_ZERO;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    state_r <= ST_ARM;
                    cnt_r   <= CNT_ZERO;
                end
                ST_ARM: begin
                    if (edge_s) begin
                        state_r <= ST_MEAS;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        state_r <= ST_ARM;
                        cnt_r   <= CNT_ZERO;
                    end
                end
                ST_MEAS: begin
                    if (edge_s) begin
                        state_r <= ST_MEAS;
                        cnt_r   <= CNT_ONE;
                    end else if (cnt_r == MAX_PERIOD) begin
                        // Silence for a full window: give up and wait for a fresh first edge
                        state_r   <= ST_ARM;
                        cnt_r     <= CNT_ZERO;
                        timeout_r <= 1'b1;
                    end else begin
                        state_r <= ST_MEAS;
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Result register and valid/ready handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            period_r       <= CNT_ZERO;
            period_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else if (emit_s) begin
            // Overrun only when an unaccepted value is being replaced
            period_r       <= cnt_r;
            period_valid_r <= 1'b1;
            overrun_r      <= period_valid_r & ~period_ready;
        end else if (accept_s) begin
            period_r       <= period_r;
            period_valid_r <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            period_r       <= period_r;
            period_valid_r <= period_valid_r;
            overrun_r      <= overrun_r;
        end
    end

    assign period       = period_r;
    assign period_valid = period_valid_r;
    assign overrun      = overrun_r;
    assign timeout      = timeout_r;

endmodule

// File: tb/tb_pulse_period_meter.sv
// Self-checking bench for pulse_period_meter: accepted results are matched against a
// queue of expected periods; flags and reset behaviour are checked directly.
module tb_pulse_period_meter;

    logic        clk;
    logic        rst;
    logic        en;
    logic        tick;
    logic [31:0] period;
    logic        period_valid;
    logic        period_ready;
    logic        overrun;
    logic        timeout;

    int          n_checks;
    int          n_errors;
    int          timeout_seen;
    int          overrun_seen;
    int          ovr_base;
    int          tmo_base;
    logic [31:0] exp_q[$];
    logic [31:0] exp_val;

    pulse_period_meter #(
        .WIDTH      (32),
        .MAX_PERIOD (32'd16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .tick         (tick),
        .period       (period),
        .period_valid (period_valid),
        .period_ready (period_ready),
        .overrun      (overrun),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rearm();
        tick = 1'b0;
        en   = 1'b0;
        cyc();
        en   = 1'b1;
        cyc();
    endtask

    // K one-cycle pulses spaced N cycles apart
    task automatic pulse_train(input int n, input int k, input bit first_completes);
        for (int i = 0; i < k; i++) begin
            if (i > 0 || first_completes) exp_q.push_back(32'(n));
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            repeat (n - 1) cyc();
        end
    endtask

    // Scoreboard: every accepted result must match the next expected period
    always @(negedge clk) begin
        if (!rst) begin
            if (timeout) timeout_seen++;
            if (overrun) overrun_seen++;
            if (period_valid && period_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_extra_result", 32'(exp_q.size()), 32'd1);
                end else begin
                    exp_val = exp_q.pop_front();
                    chk("sb_period", period, exp_val);
                end
            end
        end
    end

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        timeout_seen = 0;
        overrun_seen = 0;
        rst          = 1'b1;
        en           = 1'b0;
        tick         = 1'b1;
        period_ready = 1'b0;
        repeat (3) cyc();
        chk("rst_period", period, 32'd0);
        chk("rst_valid", 32'(period_valid), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);

        // tick already high at reset release must not count as an edge
        rst = 1'b0;
        en  = 1'b1;
        period_ready = 1'b1;
        repeat (3) cyc();
        tick = 1'b0;
        repeat (2) cyc();

        // Steady period-4 ticks
        ovr_base = overrun_seen;
        tmo_base = timeout_seen;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (3) cyc();
        chk("p4_no_early_valid", 32'(period_valid), 32'd0);
        exp_q.push_back(32'd4);
        tick = 1'b1;
        cyc();
        chk("p4_first_valid", 32'(period_valid), 32'd1);
        chk("p4_first_period", period, 32'd4);
        tick = 1'b0;
        repeat (3) cyc();
        pulse_train(4, 4, 1'b1);
        chk("p4_overrun_cycles", 32'(overrun_seen - ovr_base), 32'd0);
        chk("p4_timeout_cycles", 32'(timeout_seen - tmo_base), 32'd0);

        // Timeout after a lone edge, then a fresh measurement
        rearm();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        for (int p = 1; p < 20; p++) begin
            chk($sformatf("tmo_pos%0d", p), 32'(timeout), (p == 17) ? 32'd1 : 32'd0);
            if (p == 17) chk("tmo_no_valid", 32'(period_valid), 32'd0);
            cyc();
        end
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (4) cyc();
        exp_q.push_back(32'd5);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("tmo_rearm_period", period, 32'd5);

        // Consumer stalled for three period-5 results
        rearm();
        period_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            if (k >= 1) begin
                chk($sformatf("stall_valid%0d", k), 32'(period_valid), 32'd1);
                chk($sformatf("stall_period%0d", k), period, 32'd5);
                chk($sformatf("stall_overrun%0d", k), 32'(overrun), (k >= 2) ? 32'd1 : 32'd0);
            end
            if (k < 3) repeat (4) cyc();
        end
        exp_q.push_back(32'd5);
        period_ready = 1'b1;
        cyc();
        period_ready = 1'b0;
        chk("stall_drain_valid", 32'(period_valid), 32'd0);
        chk("stall_drain_overrun", 32'(overrun), 32'd0);

        // Long-high tick: 10 high, 6 low, high again -> one result of 16 (= timeout limit)
        period_ready = 1'b1;
        rearm();
        tmo_base = timeout_seen;
        tick = 1'b1;
        repeat (10) cyc();
        tick = 1'b0;
        repeat (6) cyc();
        exp_q.push_back(32'd16);
        tick = 1'b1;
        cyc();
        chk("hold_period", period, 32'd16);
        repeat (3) cyc();
        tick = 1'b0;
        repeat (2) cyc();
        chk("hold_no_timeout", 32'(timeout_seen - tmo_base), 32'd0);

        // New result in the same cycle the consumer accepts the old one
        period_ready = 1'b0;
        rearm();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (2) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("sim_pre_overrun", 32'(overrun), 32'd1);
        repeat (6) cyc();
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd7);
        tick = 1'b1;
        period_ready = 1'b1;
        cyc();
        tick = 1'b0;
        chk("sim_period", period, 32'd7);
        chk("sim_valid", 32'(period_valid), 32'd1);
        chk("sim_overrun", 32'(overrun), 32'd0);
        cyc();

        // en dropped for one cycle mid-measurement, with an edge in that cycle
        period_ready = 1'b0;
        rearm();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (3) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        en   = 1'b0;
        tick = 1'b1;
        cyc();
        en   = 1'b1;
        tick = 1'b0;
        chk("en_kept_valid", 32'(period_valid), 32'd1);
        chk("en_kept_period", period, 32'd4);
        repeat (2) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (5) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("en_new_period", period, 32'd6);
        chk("en_overrun", 32'(overrun), 32'd1);
        exp_q.push_back(32'd6);
        period_ready = 1'b1;
        cyc();
        period_ready = 1'b0;
        chk("en_drained", 32'(period_valid), 32'd0);

        // Reset mid-measurement with a pending result
        rearm();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        repeat (4) cyc();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("rst2_pending", 32'(period_valid), 32'd1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rst2_period", period, 32'd0);
        chk("rst2_valid", 32'(period_valid), 32'd0);
        chk("rst2_overrun", 32'(overrun), 32'd0);
        chk("rst2_timeout", 32'(timeout), 32'd0);
        period_ready = 1'b1;
        cyc();
        pulse_train(3, 3, 1'b0);
        repeat (3) cyc();

        chk("sb_leftover", 32'(exp_q.size()), 32'd0);
        chk("timeout_total", 32'(timeout_seen), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
